// File: rtl/ssd_scan_controller.sv
// Multiplexed common-anode 7-segment scanner: per-slot guard blanking, leading-zero
// suppression and a double-buffered display value that swaps only at frame boundaries.
module ssd_scan_controller #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic                    lz_suppress,
    output logic                    load_ack,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_start
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned ValW = 4 * NUM_DIGITS;

    localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] GuardEnd = CntW'(GUARD_CYCLES);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [ValW-1:0]       disp_q, disp_d;
    logic [ValW-1:0]       pend_q, pend_d;
    logic                  pflag_q, pflag_d;
    logic                  ack_q, ack_d;
    logic                  lz_q, lz_d;

    logic                  slot_end;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] supp;
    logic                  zero_run;
    logic [3:0]            slot_nib;

    // Active-low gfedcba segment patterns.
    function automatic logic [6:0] ssd_decode(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    always_comb begin
        slot_end  = (cnt_q == CntLast);
        frame_end = slot_end && (idx_q == IdxLast);

        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        disp_d  = disp_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;
        ack_d   = 1'b0;
        lz_d    = lz_suppress;

        if (slot_end) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end

        if (frame_end && pflag_q) begin
            disp_d  = pend_q;
            pflag_d = 1'b0;
            ack_d   = 1'b1;
        end

        // Applied after the transfer so a coincident load lands in pend for next frame.
        if (load) begin
            pend_d  = value_in;
            pflag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            pflag_q <= 1'b0;
            ack_q   <= 1'b0;
            lz_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
            ack_q   <= ack_d;
            lz_q    <= lz_d;
        end
    end

    // supp[k]: digits NUM_DIGITS-1..k all zero; digit 0 is never blanked.
    always_comb begin
        zero_run = 1'b1;
        supp     = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (disp_q[4*k +: 4] == 4'h0);
            supp[k]  = lz_q & zero_run;
        end
    end

    always_comb begin
        slot_nib = disp_q[4*int'(idx_q) +: 4];
        anode_n  = '1;
        seg_out  = 7'h7F;
        if (!rst && (cnt_q >= GuardEnd)) begin
            anode_n[idx_q] = 1'b0;
            if (!supp[idx_q]) begin
                seg_out = ssd_decode(slot_nib);
            end
        end
        frame_start = (idx_q == '0) && (cnt_q == '0);
        load_ack    = ack_q;
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Scoreboarded bench: a time-based reference model queues expected outputs per cycle,
// a negedge monitor pops and compares them against the scanner.
module tb_ssd_scan_controller;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int G     = 2;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        lz_suppress;
    logic        load_ack;
    logic [6:0]  seg_out;
    logic [3:0]  anode_n;
    logic        frame_start;

    ssd_scan_controller #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .GUARD_CYCLES(G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .lz_suppress(lz_suppress),
        .load_ack   (load_ack),
        .seg_out    (seg_out),
        .anode_n    (anode_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [6:0] seg;
        logic [3:0] an;
        logic       fs;
        logic       ack;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: t counts cycles since the last reset.
    int          t;
    logic [15:0] disp_m, pend_m;
    bit          pflag_m, ack_m, lz_m;

    task automatic model_reset();
        t = 0; disp_m = '0; pend_m = '0; pflag_m = 0; ack_m = 0; lz_m = 0;
    endtask

    task automatic chk(input string name, input int tt, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, tt, act, req);
        end
    endtask

    task automatic cycle(input bit r, input bit ld, input logic [15:0] v, input bit lz);
        exp_t e;
        int   pos, dig;
        bit   boundary;
        rst = r; load = ld; value_in = v; lz_suppress = lz;
        pos = t % DIV;
        dig = (t / DIV) % N;
        e.t   = t;
        e.seg = 7'h7F;
        e.an  = 4'hF;
        if (!r && pos >= G) begin
            e.an = ~(4'b0001 << dig);
            if (!(lz_m && dig != 0 && (disp_m >> (4 * dig)) == 0))
                e.seg = segtab[(disp_m >> (4 * dig)) & 16'hF];
        end
        e.fs  = (t % FRAME) == 0;
        e.ack = ack_m;
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            boundary = (t % FRAME) == FRAME - 1;
            ack_m = boundary && pflag_m;
            if (ack_m) begin
                disp_m  = pend_m;
                pflag_m = 0;
            end
            if (ld) begin
                pend_m  = v;
                pflag_m = 1;
            end
            lz_m = lz;
            t++;
        end
        #1;
    endtask

    task automatic run(input int n, input bit lz, input int ld_at, input logic [15:0] v);
        for (int i = 0; i < n; i++) cycle(0, (t == ld_at), v, lz);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("seg_out", e.t, 32'(seg_out), 32'(e.seg));
                chk("anode_n", e.t, 32'(anode_n), 32'(e.an));
                chk("frame_start", e.t, 32'(frame_start), 32'(e.fs));
                chk("load_ack", e.t, 32'(load_ack), 32'(e.ack));
            end
        end
    end

    initial begin : stim
        bit lz_r;
        bit ld_r;
        rst = 1; load = 0; value_in = '0; lz_suppress = 0;
        @(posedge clk);
        model_reset();
        #1;

        // Blank frame, then 12AF loaded at cycle 3 and shown in frame 2.
        cycle(1, 0, '0, 0);
        run(64, 0, 3, 16'h12AF);

        // Leading-zero suppression on 0050, then on an all-zero display.
        cycle(1, 0, '0, 1);
        run(64, 1, 0, 16'h0050);
        cycle(1, 0, '0, 1);
        run(32, 1, -1, '0);

        // Two loads in one frame: last write wins, single ack.
        cycle(1, 0, '0, 0);
        for (int i = 0; i < 64; i++)
            cycle(0, (t == 5) || (t == 20), (t == 5) ? 16'h1111 : 16'h2222, 0);

        // Load on the boundary edge with nothing pending waits a full frame.
        cycle(1, 0, '0, 0);
        run(96, 0, 31, 16'h3333);

        // Reset mid-frame drops the pending value.
        cycle(1, 0, '0, 0);
        run(13, 0, 5, 16'hBEEF);
        cycle(1, 0, '0, 0);
        run(64, 0, -1, '0);

        // Randomized traffic, biased towards loads on the boundary edge.
        lz_r = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 63) == 0) lz_r = ~lz_r;
            if ((t % FRAME) == FRAME - 1) ld_r = $urandom_range(0, 1) == 1;
            else                          ld_r = $urandom_range(0, 19) == 0;
            cycle($urandom_range(0, 399) == 0, ld_r, 16'($urandom), lz_r);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
